// File: rtl/write_fmps_test_link_if.sv
// AXI-Stream TX bundle between the FMPS test packet generator and the Aurora TX user port.
// A word transfers on a rising clock edge where tvalid and tready are both high; once tvalid rises, tdata/tlast hold until that transfer.
interface write_fmps_test_link_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/write_fmps_test_link.sv
// Synthetic FMPS packet generator for Aurora link testing: each accepted strobe queues
// one or more two-word packets (header, data) tagged with a per-FA-cycle index and FA cycle count.
module write_fmps_test_link #(
    parameter string       WITH_MULT_PACK_SUPPORT = "true",
    parameter logic [15:0] DATA_MAGIC             = 16'hCACA,
    parameter logic [15:0] HEADER_MAGIC           = 16'hB6CF
) (
    input  logic                          auroraUserClk,
    input  logic                          auroraReset,
    input  logic [31:0]                   sysFMPSCSR,
    input  logic                          genPacketStrobe,
    input  logic                          auroraFAstrobe,
    input  logic                          auroraChannelUp,
    write_fmps_test_link_if.master        FMPS_TEST_AXI_STREAM_TX,
    output logic [1:0]                    dbg_state,
    output logic [7:0]                    dbg_pending,
    output logic [7:0]                    dbg_fa_count,
    output logic [4:0]                    dbg_index
);

    localparam bit MULT_EN = (WITH_MULT_PACK_SUPPORT == "true");

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  fa_count_q, fa_count_d;
    logic [4:0]  index_q, index_d;
    logic [4:0]  pkt_index_q, pkt_index_d;
    logic [7:0]  pending_q, pending_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;

    logic        tready;
    logic        chan_up;
    logic        handshake;
    logic        pkt_done;
    logic [4:0]  burst_size;
    logic [8:0]  pending_sum;
    logic [31:0] header_word;
    logic [31:0] data_word;
    logic        unused_csr_bits;

    assign tready          = FMPS_TEST_AXI_STREAM_TX.tready;
    assign chan_up         = auroraChannelUp;
    assign unused_csr_bits = ^{sysFMPSCSR[29], sysFMPSCSR[23:0]};

    assign FMPS_TEST_AXI_STREAM_TX.tdata  = tdata_q;
    assign FMPS_TEST_AXI_STREAM_TX.tvalid = tvalid_q;
    assign FMPS_TEST_AXI_STREAM_TX.tlast  = tlast_q;

    assign dbg_state    = state_q;
    assign dbg_pending  = pending_q;
    assign dbg_fa_count = fa_count_q;
    assign dbg_index    = index_q;

    // Counters: FA strobe resets the index even when it coincides with a packet completion.
    always_comb begin
        handshake = tvalid_q && tready;
        pkt_done  = (state_q == ST_DATA) && handshake && chan_up;

        if (MULT_EN && (sysFMPSCSR[28:24] != 5'd0)) begin
            burst_size = sysFMPSCSR[28:24];
        end else begin
            burst_size = 5'd1;
        end

        fa_count_d = fa_count_q;
        if (auroraFAstrobe) begin
            fa_count_d = fa_count_q + 8'd1;
        end

        index_d = index_q;
        if (pkt_done) begin
            index_d = index_q + 5'd1;
        end
        if (auroraFAstrobe) begin
            index_d = 5'd0;
        end

        pending_sum = {1'b0, pending_q};
        if (pkt_done) begin
            pending_sum = pending_sum - 9'd1;
        end
        if (genPacketStrobe && chan_up) begin
            pending_sum = pending_sum + {4'd0, burst_size};
        end

        if (!chan_up) begin
            pending_d = 8'd0;
        end else if (pending_sum[8]) begin
            pending_d = 8'hFF;
        end else begin
            pending_d = pending_sum[7:0];
        end
    end

    // Word images are built from the values the packet will own once the edge has passed.
    always_comb begin
        header_word = {HEADER_MAGIC, 1'b0, index_d, 10'b0};
        data_word   = {sysFMPSCSR[31], sysFMPSCSR[30], 1'b0, pkt_index_q,
                       DATA_MAGIC, fa_count_q};
    end

    always_comb begin
        state_d     = state_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        pkt_index_d = pkt_index_q;

        case (state_q)
            ST_IDLE: begin
                if ((pending_q != 8'd0) && chan_up) begin
                    state_d     = ST_HEADER;
                    tvalid_d    = 1'b1;
                    tlast_d     = 1'b0;
                    tdata_d     = header_word;
                    pkt_index_d = index_d;
                end
            end
            ST_HEADER: begin
                if (handshake) begin
                    state_d = ST_DATA;
                    tlast_d = 1'b1;
                    tdata_d = data_word;
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    if (pending_d != 8'd0) begin
                        state_d     = ST_HEADER;
                        tlast_d     = 1'b0;
                        tdata_d     = header_word;
                        pkt_index_d = index_d;
                    end else begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        // Losing the link abandons whatever packet is in flight.
        if (!chan_up) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            state_q     <= ST_IDLE;
            fa_count_q  <= 8'd0;
            index_q     <= 5'd0;
            pkt_index_q <= 5'd0;
            pending_q   <= 8'd0;
            tdata_q     <= 32'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fa_count_q  <= fa_count_d;
            index_q     <= index_d;
            pkt_index_q <= pkt_index_d;
            pending_q   <= pending_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    hold_while_stalled: assert property (
        @(posedge auroraUserClk) disable iff (auroraReset)
        (tvalid_q && !tready && auroraChannelUp) |=>
            (tvalid_q && $stable(tdata_q) && $stable(tlast_q))
    );

    tlast_only_with_valid: assert property (
        @(posedge auroraUserClk) disable iff (auroraReset)
        tlast_q |-> tvalid_q
    );

endmodule

// File: tb/tb_write_fmps_test_link.sv
// Randomised scoreboard bench for write_fmps_test_link: a packet-level model queues expected
// words per strobe, and a negedge monitor pops and compares on every stream transfer.
module tb_write_fmps_test_link;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] csr;
    logic        gen;
    logic        fa;
    logic        chan;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_pending;
    logic [7:0]  dbg_fa_count;
    logic [4:0]  dbg_index;

    logic        rand_ready = 1'b0;
    logic        rnd_ready  = 1'b0;
    logic        fixed_ready;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    int          m_fa;
    int          m_index;

    logic        stall_seen;
    logic [32:0] stall_word;

    write_fmps_test_link_if axis ();

    assign axis.tready = rand_ready ? rnd_ready : fixed_ready;

    write_fmps_test_link dut (
        .auroraUserClk           (clk),
        .auroraReset             (rst),
        .sysFMPSCSR              (csr),
        .genPacketStrobe         (gen),
        .auroraFAstrobe          (fa),
        .auroraChannelUp         (chan),
        .FMPS_TEST_AXI_STREAM_TX (axis),
        .dbg_state               (dbg_state),
        .dbg_pending             (dbg_pending),
        .dbg_fa_count            (dbg_fa_count),
        .dbg_index               (dbg_index)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        gen = 1'b0;
        fa  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_fa    = 0;
        m_index = 0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [32:0] model_header(int idx);
        logic [31:0] w;
        w = 32'hB6CF_0000 + (32'(idx % 32) << 10);
        return {1'b0, w};
    endfunction

    function automatic logic [32:0] model_data(int idx, int fac, logic [31:0] c);
        logic [31:0] w;
        w = 32'h00CA_CA00 + (32'(idx % 32) << 24) + 32'(fac % 256);
        if (c[31]) w = w + 32'h8000_0000;
        if (c[30]) w = w + 32'h4000_0000;
        return {1'b1, w};
    endfunction

    // Packet-level model: a burst is expanded into words the moment the strobe is issued.
    task automatic model_gen();
        int b;
        if (!chan) return;
        b = int'(csr[28:24]);
        if (b == 0) b = 1;
        for (int p = 0; p < b; p++) begin
            exp_q.push_back(model_header(m_index));
            exp_q.push_back(model_data(m_index, m_fa, csr));
            m_index = (m_index + 1) % 32;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic gen_strobe();
        @(posedge clk);
        #1;
        gen = 1'b1;
        model_gen();
        @(posedge clk);
        #1;
        gen = 1'b0;
    endtask

    task automatic fa_strobes(int n);
        @(posedge clk);
        #1;
        fa = 1'b1;
        for (int i = 0; i < n; i++) begin
            m_fa    = (m_fa + 1) % 256;
            m_index = 0;
        end
        repeat (n) @(posedge clk);
        #1;
        fa = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_timeout_words_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_hold", {axis.tvalid, axis.tlast, axis.tdata}, {1'b1, stall_word});
            end
            stall_seen = axis.tvalid && !axis.tready && chan;
            stall_word = {axis.tlast, axis.tdata};
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none",
                             {axis.tlast, axis.tdata});
                end else begin
                    check("stream_word", {axis.tlast, axis.tdata}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int run;
        int abandoned;
        rst         = 1'b1;
        gen         = 1'b0;
        fa          = 1'b0;
        chan        = 1'b0;
        csr         = 32'h0100_0000;
        fixed_ready = 1'b1;
        m_fa        = 0;
        m_index     = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_tvalid", axis.tvalid, 0);
        check("reset_tlast", axis.tlast, 0);
        check("reset_tdata", axis.tdata, 0);
        check("reset_state", dbg_state, 0);
        check("reset_counters", {dbg_pending, dbg_fa_count, dbg_index}, 0);
        do_reset();

        // Channel down: strobes ignored, FA count still advances
        chan = 1'b0;
        fa_strobes(3);
        gen_strobe();
        gen_strobe();
        run = 0;
        repeat (10) begin
            @(negedge clk);
            if (axis.tvalid) run++;
        end
        check("down_tvalid_cycles", run, 0);
        check("down_fa_count", dbg_fa_count, m_fa);
        check("down_pending", dbg_pending, 0);
        @(posedge clk);
        #1;
        chan = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("up_no_stale_burst", axis.tvalid, 0);

        // Burst after first FA strobe
        do_reset();
        chan = 1'b1;
        csr  = 32'h0100_0000;
        fa_strobes(1);
        for (int i = 0; i < 8; i++) begin
            gen_strobe();
            repeat (7) @(posedge clk);
        end
        wait_drain(100);
        check("index_after_burst", dbg_index, m_index);
        check("pending_after_burst", dbg_pending, 0);

        // Same stimulus under random back-pressure
        do_reset();
        chan       = 1'b1;
        rand_ready = 1'b1;
        fa_strobes(1);
        for (int i = 0; i < 8; i++) begin
            gen_strobe();
            repeat (7) @(posedge clk);
        end
        wait_drain(400);
        rand_ready = 1'b0;

        // Multi-packet burst: latency and back-to-back occupancy
        csr = 32'h0300_0000;
        @(posedge clk);
        #1;
        gen = 1'b1;
        model_gen();
        @(posedge clk);
        #1;
        gen = 1'b0;
        @(negedge clk);
        check("latency_not_early", axis.tvalid, 0);
        @(negedge clk);
        check("latency_header", axis.tvalid, 1);
        run = 0;
        while (axis.tvalid && run < 20) begin
            run++;
            @(negedge clk);
        end
        check("b2b_valid_cycles", run, 6);
        wait_drain(50);

        // Zero burst field means one packet
        csr = 32'h0000_0000;
        gen_strobe();
        wait_drain(50);

        // Forced flags and FA counter wrap
        do_reset();
        chan = 1'b1;
        csr  = 32'hC100_0000;
        fa_strobes(255);
        @(negedge clk);
        check("fa_count_255", dbg_fa_count, m_fa);
        fa_strobes(1);
        @(negedge clk);
        check("fa_count_wrap", dbg_fa_count, m_fa);
        gen_strobe();
        wait_drain(50);

        // Randomised bursts, flags, FA strobes and back-pressure
        for (int it = 0; it < 20; it++) begin
            csr = {$urandom_range(0, 7), 5'($urandom_range(0, 4)), 24'($urandom)};
            if ($urandom_range(0, 1) == 1) fa_strobes($urandom_range(1, 3));
            rand_ready = ($urandom_range(0, 1) == 1);
            for (int s = 0; s < $urandom_range(1, 2); s++) begin
                gen_strobe();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            wait_drain(300);
            rand_ready = 1'b0;
        end

        // Channel drop while the data word is presented
        do_reset();
        chan        = 1'b1;
        csr         = 32'h0100_0000;
        fixed_ready = 1'b0;
        gen_strobe();
        run = 0;
        @(negedge clk);
        while (!axis.tvalid && run < 10) begin
            run++;
            @(negedge clk);
        end
        check("drop_header_seen", axis.tvalid, 1);
        @(posedge clk);
        #1;
        fixed_ready = 1'b1;
        @(posedge clk);
        #1;
        fixed_ready = 1'b0;
        chan        = 1'b0;
        abandoned   = (exp_q.size() + 1) / 2;
        m_index     = (m_index - abandoned + 32) % 32;
        exp_q.delete();
        @(negedge clk);
        check("drop_in_data", {axis.tvalid, axis.tlast}, 2'b11);
        @(negedge clk);
        check("drop_tvalid", axis.tvalid, 0);
        check("drop_pending", dbg_pending, 0);
        check("drop_state_idle", dbg_state, 0);
        @(posedge clk);
        #1;
        chan        = 1'b1;
        fixed_ready = 1'b1;
        repeat (3) @(posedge clk);
        gen_strobe();
        wait_drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
